// File: rtl/full_adder_pkg.sv
// full_adder_pkg: shared constants for the full_adder slice.
package full_adder_pkg;
   localparam int DEFAULT_WIDTH = 1;
endpackage

// File: rtl/full_adder_bit.sv
// full_adder_bit: one ripple cell; a + b + cin -> s, cout.
//   a, b, cin : 1-bit addends and incoming carry
//   s, cout   : 1-bit sum and outgoing carry
module full_adder_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/full_adder.sv
// full_adder: WIDTH-bit ripple adder with combinational S/C/V and a registered copy.
//   clk, rst             : clock, synchronous active-high reset
//   A, B, Cin, en        : operands, carry-in, register capture enable
//   S, C, V              : combinational sum, carry-out, signed overflow
//   S_q, C_q, V_q, valid_q : registered result, valid the cycle after a capture
module full_adder
   import full_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             en,
   output logic [WIDTH-1:0] S,
   output logic             C,
   output logic             V,
   output logic [WIDTH-1:0] S_q,
   output logic             C_q,
   output logic             V_q,
   output logic             valid_q
);
   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] S_d;
   logic             C_d;
   logic             V_d;
   logic             valid_d;
   assign c[0] = Cin;
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      full_adder_bit u_bit (
         .a    (A[i]),
         .b    (B[i]),
         .cin  (c[i]),
         .s    (S[i]),
         .cout (c[i+1])
      );
   end
   assign C = c[WIDTH];
   // carry into the MSB vs carry out of it; for WIDTH=1 the carry in is Cin
   assign V = c[WIDTH-1] ^ c[WIDTH];
   always_comb begin
      S_d     = en ? S : S_q;
      C_d     = en ? C : C_q;
      V_d     = en ? V : V_q;
      valid_d = en;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         S_q     <= '0;
         C_q     <= 1'b0;
         V_q     <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         S_q     <= S_d;
         C_q     <= C_d;
         V_q     <= V_d;
         valid_q <= valid_d;
      end
   end
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: scoreboard bench for full_adder at WIDTH=1 and WIDTH=4.
module tb_full_adder;
   typedef struct {
      string      name;
      int         sel;
      logic [7:0] exp;
   } item_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic       a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
   logic       s1, c1, v1, sq1, cq1, vq1, valq1;
   logic [3:0] a4 = '0, b4 = '0, s4, sq4;
   logic       cin4 = 1'b0, c4, v4, cq4, vq4, valq4;
   item_t      q[$];
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   full_adder #(.WIDTH(1)) u1 (
      .clk(clk), .rst(rst), .A(a1), .B(b1), .Cin(cin1), .en(en),
      .S(s1), .C(c1), .V(v1), .S_q(sq1), .C_q(cq1), .V_q(vq1), .valid_q(valq1)
   );

   full_adder #(.WIDTH(4)) u4 (
      .clk(clk), .rst(rst), .A(a4), .B(b4), .Cin(cin4), .en(1'b1),
      .S(s4), .C(c4), .V(v4), .S_q(sq4), .C_q(cq4), .V_q(vq4), .valid_q(valq4)
   );

   // monitor: sel 0 = w1 {V,C,S}, sel 1 = w4 {V,C,S[3:0]}, sel 2 = w1 {valid_q,V_q,C_q,S_q}
   initial begin
      item_t      it;
      logic [7:0] act;
      forever begin
         wait (q.size() > 0);
         it  = q.pop_front();
         act = it.sel == 0 ? {5'b0, v1, c1, s1} :
               it.sel == 1 ? {1'b0, v4, c4, s4} : {4'b0, valq1, vq1, cq1, sq1};
         checks++;
         if (act !== it.exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", it.name, act, it.exp);
         end
      end
   end

   task automatic expect_it(input string name, input int sel, input logic [7:0] exp);
      item_t it;
      it.name = name;
      it.sel  = sel;
      it.exp  = exp;
      q.push_back(it);
   endtask

   task automatic comb1(input logic [2:0] cba, input logic [2:0] vcs);
      {cin1, b1, a1} = cba;
      #1 expect_it($sformatf("w1 cin,b,a=%b", cba), 0, {5'b0, vcs});
      #9;
   endtask

   task automatic comb4(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic [5:0] vcs);
      a4 = a; b4 = b; cin4 = ci;
      #1 expect_it($sformatf("w4 %h+%h+%b", a, b, ci), 1, {2'b0, vcs});
      #9;
   endtask

   task automatic reg_step(input string name, input logic r, input logic e, input logic [2:0] cba, input logic [3:0] exp);
      @(negedge clk);
      rst = r; en = e; {cin1, b1, a1} = cba;
      @(posedge clk);
      #1 expect_it(name, 2, {4'b0, exp});
   endtask

   initial begin
      // {Cin,B,A} -> {V,C,S}
      comb1(3'b001, 3'b001);
      comb1(3'b010, 3'b001);
      comb1(3'b011, 3'b110);
      comb1(3'b100, 3'b101);
      comb1(3'b101, 3'b010);
      comb1(3'b110, 3'b010);
      comb1(3'b111, 3'b011);
      comb1(3'b000, 3'b000);
      comb4(4'hF, 4'h0, 1'b1, {1'b0, 1'b1, 4'h0});
      comb4(4'h7, 4'h1, 1'b0, {1'b1, 1'b0, 4'h8});
      comb4(4'h5, 4'h3, 1'b0, {1'b1, 1'b0, 4'h8});
      comb4(4'hF, 4'hF, 1'b1, {1'b0, 1'b1, 4'hF});
      comb4(4'h8, 4'h8, 1'b0, {1'b1, 1'b1, 4'h0});
      comb4(4'h2, 4'h3, 1'b0, {1'b0, 1'b0, 4'h5});
      // {valid_q,V_q,C_q,S_q}
      reg_step("reset", 1'b1, 1'b0, 3'b000, 4'b0000);
      reg_step("capture 1+1+1", 1'b0, 1'b1, 3'b111, 4'b1011);
      @(negedge clk);
      en = 1'b0; {cin1, b1, a1} = 3'b000;
      #1 expect_it("hold comb 0+0+0", 0, 8'b000);
      @(posedge clk);
      #1 expect_it("hold regs", 2, 8'b0011);
      reg_step("capture 0+0+1 V", 1'b0, 1'b1, 3'b100, 4'b1101);
      reg_step("capture 1+0+0", 1'b0, 1'b1, 3'b001, 4'b1001);
      @(negedge clk);
      rst = 1'b1; en = 1'b0;
      #2 expect_it("rst between edges", 2, 8'b1001);
      @(posedge clk);
      #1 expect_it("sync reset edge", 2, 8'b0000);
      reg_step("recapture 1+1+0", 1'b0, 1'b1, 3'b011, 4'b1110);
      @(negedge clk);
      rst = 1'b1; en = 1'b1; {cin1, b1, a1} = 3'b011;
      #1 expect_it("rst comb C visible", 0, 8'b110);
      @(posedge clk);
      #1 expect_it("rst over en", 2, 8'b0000);
      #1 expect_it("comb after rst", 0, 8'b110);
      for (int i = 0; i < 100 && q.size() > 0; i++) #1;
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d pending expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
